byte_serial_mem_port: RTL and testbench

Parametrised byte-serial memory port that moves one DATA_W-bit word between the register datapath and the 8-bit-wide Memory. A single Start request runs 1..DATA_W/8 consecutive byte cycles. Each request selects a load or store, little- or big-endian byte order, and zero- or sign-extension. The block sits between the datapath (ALU/DR side) and Memory, replacing hand-sequenced per-byte MuxC and DR_FunSel control with one handshake.

---
 rtl/byte_serial_mem_port_if.sv | 38 +++
 rtl/byte_serial_mem_port.sv | 113 +++++++++++
 tb/tb_byte_serial_mem_port.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serial_mem_port_if.sv
// Request/memory bundle for the byte-serial memory port.
// master: datapath plus memory side; slave: the port itself.
interface byte_serial_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    localparam int CNT_W = $clog2(DATA_W / 8) + 1;

    logic              Start;
    logic              Write;
    logic              BigEnd;
    logic              SignExt;
    logic [CNT_W-1:0]  NumBytes;
    logic [ADDR_W-1:0] BaseAddr;
    logic [DATA_W-1:0] WData;
    logic [7:0]        MemOut;
    logic [ADDR_W-1:0] Mem_Address;
    logic [7:0]        Mem_Data;
    logic              Mem_CS;
    logic              Mem_WR;
    logic [DATA_W-1:0] RData;
    logic              Busy;
    logic              Done;

    modport master (
        output Start, Write, BigEnd, SignExt,
        output NumBytes, BaseAddr, WData, MemOut,
        input  Mem_Address, Mem_Data, Mem_CS, Mem_WR,
        input  RData, Busy, Done
    );

    modport slave (
        input  Start, Write, BigEnd, SignExt,
        input  NumBytes, BaseAddr, WData, MemOut,
        output Mem_Address, Mem_Data, Mem_CS, Mem_WR,
        output RData, Busy, Done
    );
endinterface

// File: rtl/byte_serial_mem_port.sv
// Byte-serial load/store port between the register datapath
// and the 8-bit memory: one request moves 1..DATA_W/8 bytes.
module byte_serial_mem_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input logic Clock,
    input logic Reset,
    byte_serial_mem_port_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB) + 1;
    localparam int IW    = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q;
    logic              write_q;
    logic              be_q;
    logic              sext_q;
    logic              done_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  i_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] rdata_q;

    logic [CNT_W-1:0]  n_d;
    logic [CNT_W-1:0]  lane;
    logic [IW-1:0]     lane_b;
    logic [IW-1:0]     sidx;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] rdata_d;
    logic              last;
    logic              sign;
    logic              xfer;

    always_comb begin
        n_d = bus.NumBytes;
        if (bus.NumBytes == '0 || bus.NumBytes > CNT_W'(NB))
            n_d = CNT_W'(NB);
        lane   = be_q ? (n_q - CNT_W'(1) - i_q) : i_q;
        lane_b = IW'(8 * int'(lane));
        last   = (i_q == n_q - CNT_W'(1));
        acc_d  = acc_q;
        acc_d[lane_b +: 8] = bus.MemOut;
        // Sign bit is the top bit of the highest transferred lane
        sidx    = IW'(8 * int'(n_q) - 1);
        sign    = sext_q & acc_d[sidx];
        rdata_d = '0;
        for (int b = 0; b < DATA_W; b++)
            rdata_d[b] = (b < 8 * int'(n_q)) ? acc_d[b] : sign;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            be_q    <= 1'b0;
            sext_q  <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= CNT_W'(NB);
            i_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        write_q <= bus.Write;
                        be_q    <= bus.BigEnd;
                        sext_q  <= bus.SignExt;
                        n_q     <= n_d;
                        i_q     <= '0;
                        addr_q  <= bus.BaseAddr;
                        wdata_q <= bus.WData;
                        acc_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (!write_q) acc_q <= acc_d;
                    if (last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!write_q) rdata_q <= rdata_d;
                    end else begin
                        i_q    <= i_q + CNT_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset kills the strobe at once so an aborted store stops writing
    assign xfer            = (state_q == XFER) && !Reset;
    assign bus.Mem_CS      = xfer;
    assign bus.Mem_WR      = xfer & write_q;
    assign bus.Mem_Data    = xfer ? wdata_q[lane_b +: 8] : 8'h00;
    assign bus.Mem_Address = addr_q;
    assign bus.RData       = rdata_q;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.Done        = done_q;
endmodule

// File: tb/tb_byte_serial_mem_port.sv
// Randomised bench for byte_serial_mem_port at DATA_W 32, 8, 64
// against a byte-list reference model and shadow memories.
module tb_byte_serial_mem_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_serial_mem_port_if #(.DATA_W(32), .ADDR_W(16)) if0 ();
    byte_serial_mem_port_if #(.DATA_W(8),  .ADDR_W(16)) if1 ();
    byte_serial_mem_port_if #(.DATA_W(64), .ADDR_W(16)) if2 ();

    byte_serial_mem_port #(.DATA_W(32), .ADDR_W(16)) dut0 (
        .Clock(clk), .Reset(rst), .bus(if0));
    byte_serial_mem_port #(.DATA_W(8), .ADDR_W(16)) dut1 (
        .Clock(clk), .Reset(rst), .bus(if1));
    byte_serial_mem_port #(.DATA_W(64), .ADDR_W(16)) dut2 (
        .Clock(clk), .Reset(rst), .bus(if2));

    logic        start_a [3];
    logic        wr_a    [3];
    logic        be_a    [3];
    logic        se_a    [3];
    logic [3:0]  nb_a    [3];
    logic [15:0] base_a  [3];
    logic [63:0] wd_a    [3];

    logic        cs_o   [3];
    logic        mwr_o  [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [7:0]  md_o   [3];
    logic [15:0] ad_o   [3];
    logic [63:0] rd_o   [3];

    bit [7:0] mem  [3][65536];
    bit [7:0] refm [3][65536];
    logic [63:0] rd_m [3];

    logic        pl_en = 1'b0;
    int          pl_k  = 0;
    logic [15:0] pl_a  = '0;
    logic [7:0]  pl_v  = '0;

    assign if0.Start = start_a[0];
    assign if0.Write = wr_a[0];
    assign if0.BigEnd = be_a[0];
    assign if0.SignExt = se_a[0];
    assign if0.NumBytes = nb_a[0][2:0];
    assign if0.BaseAddr = base_a[0];
    assign if0.WData = wd_a[0][31:0];
    assign if0.MemOut = mem[0][if0.Mem_Address];

    assign if1.Start = start_a[1];
    assign if1.Write = wr_a[1];
    assign if1.BigEnd = be_a[1];
    assign if1.SignExt = se_a[1];
    assign if1.NumBytes = nb_a[1][0:0];
    assign if1.BaseAddr = base_a[1];
    assign if1.WData = wd_a[1][7:0];
    assign if1.MemOut = mem[1][if1.Mem_Address];

    assign if2.Start = start_a[2];
    assign if2.Write = wr_a[2];
    assign if2.BigEnd = be_a[2];
    assign if2.SignExt = se_a[2];
    assign if2.NumBytes = nb_a[2];
    assign if2.BaseAddr = base_a[2];
    assign if2.WData = wd_a[2];
    assign if2.MemOut = mem[2][if2.Mem_Address];

    assign cs_o[0] = if0.Mem_CS;
    assign cs_o[1] = if1.Mem_CS;
    assign cs_o[2] = if2.Mem_CS;
    assign mwr_o[0] = if0.Mem_WR;
    assign mwr_o[1] = if1.Mem_WR;
    assign mwr_o[2] = if2.Mem_WR;
    assign busy_o[0] = if0.Busy;
    assign busy_o[1] = if1.Busy;
    assign busy_o[2] = if2.Busy;
    assign done_o[0] = if0.Done;
    assign done_o[1] = if1.Done;
    assign done_o[2] = if2.Done;
    assign md_o[0] = if0.Mem_Data;
    assign md_o[1] = if1.Mem_Data;
    assign md_o[2] = if2.Mem_Data;
    assign ad_o[0] = if0.Mem_Address;
    assign ad_o[1] = if1.Mem_Address;
    assign ad_o[2] = if2.Mem_Address;
    assign rd_o[0] = {32'h0, if0.RData};
    assign rd_o[1] = {56'h0, if1.RData};
    assign rd_o[2] = if2.RData;

    always @(posedge clk) begin
        if (pl_en) mem[pl_k][pl_a] <= pl_v;
        for (int k = 0; k < 3; k++)
            if (cs_o[k] && mwr_o[k]) mem[k][ad_o[k]] <= md_o[k];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int k, input logic [15:0] a,
                           input logic [7:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_k = k; pl_a = a; pl_v = v;
        refm[k][a] = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic scramble(input int k);
        wr_a[k] = 1'($urandom); be_a[k] = 1'($urandom);
        se_a[k] = 1'($urandom); nb_a[k] = 4'($urandom);
        base_a[k] = 16'($urandom); wd_a[k] = {$urandom, $urandom};
    endtask

    task automatic xact(input int k, input bit wr, input bit be,
                        input bit se, input int nb,
                        input logic [15:0] base,
                        input logic [63:0] wd, input bit noisy);
        int nbmax, cw, nbt, n;
        logic [7:0] mord[$];
        logic [7:0] lanes[$];
        logic [63:0] exp_rd, m, wm;
        logic [15:0] a;
        nbmax = (k == 0) ? 4 : (k == 1) ? 1 : 8;
        cw = (k == 0) ? 3 : (k == 1) ? 1 : 4;
        nbt = nb & ((1 << cw) - 1);
        n = (nbt == 0 || nbt > nbmax) ? nbmax : nbt;
        exp_rd = rd_m[k];
        if (wr) begin
            for (int j = 0; j < n; j++) lanes.push_back(wd[8*j +: 8]);
            mord = be ? lanes[$:0] : lanes;
            if (be) begin
                mord = {};
                for (int j = n - 1; j >= 0; j--) mord.push_back(lanes[j]);
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                a = 16'(base + j);
                mord.push_back(refm[k][a]);
            end
            lanes = mord;
            if (be) begin
                lanes = {};
                for (int j = n - 1; j >= 0; j--) lanes.push_back(mord[j]);
            end
            exp_rd = '0;
            for (int j = 0; j < n; j++) exp_rd[8*j +: 8] = lanes[j];
            m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
            wm = (nbmax == 8) ? '1 : ((64'd1 << (8 * nbmax)) - 64'd1);
            if (se && exp_rd[8*n-1]) exp_rd = (exp_rd | ~m) & wm;
        end
        @(negedge clk);
        wr_a[k] = wr; be_a[k] = be; se_a[k] = se;
        nb_a[k] = 4'(nb); base_a[k] = base; wd_a[k] = wd;
        start_a[k] = 1'b1;
        for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            if (c < n) begin
                chk("xfer_cs", 64'(cs_o[k]), 64'd1);
                chk("xfer_addr", 64'(ad_o[k]), 64'(16'(base + c)));
                chk("xfer_wr", 64'(mwr_o[k]), 64'(wr));
                if (wr) chk("xfer_data", 64'(md_o[k]), 64'(mord[c]));
                chk("xfer_done", 64'(done_o[k]), 64'd0);
                chk("xfer_busy", 64'(busy_o[k]), 64'd1);
            end else if (c == n) begin
                chk("done_pulse", 64'(done_o[k]), 64'd1);
                chk("done_busy", 64'(busy_o[k]), 64'd1);
                chk("done_cs", 64'(cs_o[k]), 64'd0);
                chk("done_wr", 64'(mwr_o[k]), 64'd0);
                chk("done_data", 64'(md_o[k]), 64'd0);
                chk("done_addr", 64'(ad_o[k]), 64'(16'(base + n - 1)));
                chk("done_rdata", rd_o[k], exp_rd);
            end else begin
                chk("idle_done", 64'(done_o[k]), 64'd0);
                chk("idle_busy", 64'(busy_o[k]), 64'd0);
                chk("idle_cs", 64'(cs_o[k]), 64'd0);
                chk("idle_rdata", rd_o[k], exp_rd);
            end
            start_a[k] = 1'b0;
            if (noisy && c <= n) begin
                scramble(k);
                start_a[k] = (c == n) ? 1'b1 : 1'($urandom);
            end
        end
        start_a[k] = 1'b0;
        if (wr) begin
            for (int j = 0; j < n; j++) begin
                a = 16'(base + j);
                chk("mem_store", 64'(mem[k][a]), 64'(mord[j]));
                refm[k][a] = mord[j];
            end
            a = 16'(base + n);
            chk("mem_untouched", 64'(mem[k][a]), 64'(refm[k][a]));
        end
        rd_m[k] = exp_rd;
    endtask

    task automatic reset_mid_store();
        @(negedge clk);
        wr_a[0] = 1'b1; be_a[0] = 1'b0; se_a[0] = 1'b0;
        nb_a[0] = 4'd4; base_a[0] = 16'h0200;
        wd_a[0] = 64'h55667788; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) rd_m[k] = '0;
        chk("rst_cs", 64'(cs_o[0]), 64'd0);
        chk("rst_wr", 64'(mwr_o[0]), 64'd0);
        chk("rst_data", 64'(md_o[0]), 64'd0);
        chk("rst_addr", 64'(ad_o[0]), 64'd0);
        chk("rst_busy", 64'(busy_o[0]), 64'd0);
        chk("rst_rdata", rd_o[0], 64'd0);
        chk("rst_byte0", 64'(mem[0][16'h0200]), 64'h88);
        chk("rst_byte1", 64'(mem[0][16'h0201]), 64'(refm[0][16'h0201]));
        refm[0][16'h0200] = 8'h88;
        for (int c = 0; c < 6; c++) begin
            chk("rst_no_done", 64'(done_o[0]), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] b;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0; wr_a[k] = 1'b0; be_a[k] = 1'b0;
            se_a[k] = 1'b0; nb_a[k] = '0; base_a[k] = '0;
            wd_a[k] = '0; rd_m[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_done", 64'(done_o[k]), 64'd0);
            chk("reset_busy", 64'(busy_o[k]), 64'd0);
            chk("reset_cs", 64'(cs_o[k]), 64'd0);
            chk("reset_wr", 64'(mwr_o[k]), 64'd0);
            chk("reset_data", 64'(md_o[k]), 64'd0);
            chk("reset_addr", 64'(ad_o[k]), 64'd0);
            chk("reset_rdata", rd_o[k], 64'd0);
        end

        preload(0, 16'h0010, 8'h11);
        preload(0, 16'h0011, 8'h22);
        preload(0, 16'h0012, 8'h33);
        preload(0, 16'h0013, 8'h44);
        xact(0, 0, 0, 0, 4, 16'h0010, 64'h0, 0);
        chk("le_load", rd_o[0], 64'h44332211);
        xact(0, 0, 1, 0, 4, 16'h0010, 64'h0, 0);
        chk("be_load", rd_o[0], 64'h11223344);
        preload(0, 16'h0020, 8'h80);
        preload(0, 16'h0021, 8'hFF);
        xact(0, 0, 0, 1, 2, 16'h0020, 64'h0, 0);
        chk("sext_load", rd_o[0], 64'hFFFFFF80);

        xact(0, 1, 1, 0, 0, 16'hFFFE, 64'hA1B2C3D4, 0);
        chk("wrap_fffe", 64'(mem[0][16'hFFFE]), 64'hA1);
        chk("wrap_ffff", 64'(mem[0][16'hFFFF]), 64'hB2);
        chk("wrap_0000", 64'(mem[0][16'h0000]), 64'hC3);
        chk("wrap_0001", 64'(mem[0][16'h0001]), 64'hD4);
        chk("store_keeps_rd", rd_o[0], 64'hFFFFFF80);

        xact(0, 1, 0, 0, 4, 16'h0100, 64'h0BADF00D, 1);
        chk("noisy_b0", 64'(mem[0][16'h0100]), 64'h0D);
        chk("noisy_b3", 64'(mem[0][16'h0103]), 64'h0B);

        reset_mid_store();
        xact(0, 0, 0, 0, 4, 16'h0200, 64'h0, 0);

        preload(1, 16'h0300, 8'hC5);
        xact(1, 0, 0, 1, 0, 16'h0300, 64'h0, 0);
        chk("w8_sext", rd_o[1], 64'hC5);
        for (int j = 0; j < 8; j++)
            preload(2, 16'(16'h0400 + j), 8'(8'h10 * j + 1));
        xact(2, 0, 1, 0, 0, 16'h0400, 64'h0, 0);
        chk("w64_be", rd_o[2], 64'h0111213141516171);
        xact(2, 1, 0, 0, 8, 16'hFFFC, 64'h8877665544332211, 0);

        for (int t = 0; t < 60; t++) begin
            int k;
            bit wr;
            k = $urandom_range(0, 2);
            wr = 1'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF9 + $urandom_range(0, 6))
                                            : 16'($urandom);
            if (!wr)
                for (int j = 0; j < 8; j++)
                    if ($urandom_range(0, 1) == 1)
                        preload(k, 16'(b + j), 8'($urandom));
            xact(k, wr, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 15), b, {$urandom, $urandom},
                 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
